// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between an instruction-fetch port
// and a data port. One access is outstanding at a time. Data wins ties unless
// fetch has already waited through MAXD data grants in a row.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2,  // read-data delay after the m_en cycle, 1..15
  parameter int unsigned MAXD    = 4   // consecutive data grants allowed while fetch waits, 1..15
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  // instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // memory side
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] MAXD_C   = 4'(MAXD);
  localparam logic [3:0] LAT_M1_C = 4'(LATENCY - 1);

  state_e      state_q,    state_d;
  logic [3:0]  starve_q,   starve_d;   // data grants taken while fetch was waiting
  logic [3:0]  cnt_q,      cnt_d;      // cycles left until m_rdata is valid
  logic        owner_q,    owner_d;    // 1 = data port owns the access
  logic        m_en_q,     m_en_d;
  logic        m_we_q,     m_we_d;
  logic [31:0] m_addr_q,   m_addr_d;   // latched winner address, also drives m_addr
  logic [31:0] m_wdata_q,  m_wdata_d;  // latched store data, also drives m_wdata
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q,  d_ready_d;
  logic        busy_q,     busy_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q,  d_rdata_d;
  logic        grant_data;

  // Data wins a tie unless fetch has been passed over MAXD times already.
  assign grant_data = d_req && !(if_req && (starve_q == MAXD_C));

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which is what would otherwise infer a latch.
    state_d    = state_q;
    starve_d   = starve_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_en_d     = 1'b0;
    m_we_d     = 1'b0;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d = grant_data;
          m_en_d  = 1'b1;
          state_d = ISSUE;
          if (grant_data) begin
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_we_d    = d_we;
            // Fetch still waiting: count this pass-over, saturating.
            if (if_req) begin
              starve_d = (starve_q == MAXD_C) ? starve_q : starve_q + 4'd1;
            end else begin
              starve_d = 4'd0;
            end
          end else begin
            m_addr_d = if_addr;
            starve_d = 4'd0;
          end
        end
      end

      ISSUE: begin
        cnt_d   = LAT_M1_C;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == 4'd0) begin
          // m_rdata is valid this cycle; stores capture it too.
          if (owner_q) begin
            d_rdata_d = m_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = m_rdata;
            if_ready_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      starve_q   <= starve_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      busy_q     <= busy_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Instance 0 uses LATENCY=2/MAXD=4 and carries
// the main sequence; instances 1 and 2 (LATENCY=1 and 15) share the request
// inputs and are checked in the latency sweep.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic [2:0]        if_ready_v, d_ready_v, m_en_v, m_we_v, busy_v;
  logic [2:0][31:0]  if_rdata_v, d_rdata_v, m_addr_v, m_wdata_v, m_rdata_v;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_c [3] = '{2, 1, 15};

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(2), .MAXD(4)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_v[0]), .if_ready(if_ready_v[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_v[0]), .d_ready(d_ready_v[0]),
    .m_en(m_en_v[0]), .m_we(m_we_v[0]), .m_addr(m_addr_v[0]), .m_wdata(m_wdata_v[0]),
    .m_rdata(m_rdata_v[0]), .busy(busy_v[0])
  );

  mem_arbiter #(.LATENCY(1), .MAXD(4)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_v[1]), .if_ready(if_ready_v[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_v[1]), .d_ready(d_ready_v[1]),
    .m_en(m_en_v[1]), .m_we(m_we_v[1]), .m_addr(m_addr_v[1]), .m_wdata(m_wdata_v[1]),
    .m_rdata(m_rdata_v[1]), .busy(busy_v[1])
  );

  mem_arbiter #(.LATENCY(15), .MAXD(4)) u_dut2 (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_v[2]), .if_ready(if_ready_v[2]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_v[2]), .d_ready(d_ready_v[2]),
    .m_en(m_en_v[2]), .m_we(m_we_v[2]), .m_addr(m_addr_v[2]), .m_wdata(m_wdata_v[2]),
    .m_rdata(m_rdata_v[2]), .busy(busy_v[2])
  );

  // Memory contents as a fixed function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C01_0004;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: data for a command appears exactly LATENCY cycles after its
  // m_en cycle; other cycles carry a changing junk value.
  logic [2:0][15:0] hen = '0;
  logic [31:0]      hadr [3][16];
  int               cyc = 0;

  initial begin
    for (int k = 0; k < 3; k++) for (int i = 0; i < 16; i++) hadr[k][i] = 32'd0;
    m_rdata_v = '0;
  end

  always begin
    @(posedge clk);
    #2;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      for (int i = 15; i > 0; i--) hadr[k][i] = hadr[k][i-1];
      hadr[k][0] = m_addr_v[k];
      hen[k]     = {hen[k][14:0], m_en_v[k]};
      m_rdata_v[k] = hen[k][lat_c[k]] ? mem_fn(hadr[k][lat_c[k]])
                                      : (32'hBAD0_0000 + 32'(cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_all_idle();
    int w = 0;
    while ((busy_v != 3'b000) && (w < 60)) begin
      tick();
      w++;
    end
    check("all_idle", 32'(busy_v), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rdy_cnt;
    int rdy_at [3];
    logic [31:0] rd_at [3];

    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_busy",     32'(busy_v[0]),     32'd0);
    check("rst_m_en",     32'(m_en_v[0]),     32'd0);
    check("rst_m_we",     32'(m_we_v[0]),     32'd0);
    check("rst_m_addr",   m_addr_v[0],        32'd0);
    check("rst_m_wdata",  m_wdata_v[0],       32'd0);
    check("rst_if_ready", 32'(if_ready_v[0]), 32'd0);
    check("rst_d_ready",  32'(d_ready_v[0]),  32'd0);
    check("rst_if_rdata", if_rdata_v[0],      32'd0);
    check("rst_d_rdata",  d_rdata_v[0],       32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch only at 0x40
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    check("f_m_en",   32'(m_en_v[0]), 32'd1);
    check("f_m_we",   32'(m_we_v[0]), 32'd0);
    check("f_m_addr", m_addr_v[0],    32'h40);
    check("f_busy",   32'(busy_v[0]), 32'd1);
    tick();
    check("f_m_en_off",  32'(m_en_v[0]), 32'd0);
    check("f_addr_hold", m_addr_v[0],    32'h40);
    tick();
    check("f_no_early_ready", 32'(if_ready_v[0]), 32'd0);
    tick();
    check("f_if_ready", 32'(if_ready_v[0]), 32'd1);
    check("f_if_rdata", if_rdata_v[0],      32'h8C01_0004);
    check("f_d_ready",  32'(d_ready_v[0]),  32'd0);
    if_req = 1'b0;
    tick();
    check("f_ready_pulse", 32'(if_ready_v[0]), 32'd0);
    check("f_idle",        32'(busy_v[0]),     32'd0);
    check("f_rdata_hold",  if_rdata_v[0],      32'h8C01_0004);

    // Store to 0x100
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("s_m_en",    32'(m_en_v[0]), 32'd1);
    check("s_m_we",    32'(m_we_v[0]), 32'd1);
    check("s_m_addr",  m_addr_v[0],    32'h100);
    check("s_m_wdata", m_wdata_v[0],   32'hDEAD_BEEF);
    tick();
    check("s_m_we_off",   32'(m_we_v[0]), 32'd0);
    check("s_wdata_hold", m_wdata_v[0],   32'hDEAD_BEEF);
    tick(); tick();
    check("s_d_ready",      32'(d_ready_v[0]),  32'd1);
    check("s_if_ready",     32'(if_ready_v[0]), 32'd0);
    check("s_d_rdata",      d_rdata_v[0],       32'h0100_FEFF);
    check("s_if_rdata_hold", if_rdata_v[0],     32'h8C01_0004);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("s_ready_pulse", 32'(d_ready_v[0]), 32'd0);

    // Simultaneous requests: data first, fetch in the next IDLE
    d_req = 1'b1; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h44;
    tick();
    check("b_first_addr", m_addr_v[0], 32'h200);
    tick(); tick(); tick();
    check("b_d_ready",  32'(d_ready_v[0]),  32'd1);
    check("b_if_wait",  32'(if_ready_v[0]), 32'd0);
    check("b_d_rdata",  d_rdata_v[0],       32'h0200_FDFF);
    d_req = 1'b0;
    tick();
    check("b_idle_gap", 32'(busy_v[0]), 32'd0);
    tick();
    check("b_second_en",   32'(m_en_v[0]), 32'd1);
    check("b_second_addr", m_addr_v[0],    32'h44);
    tick(); tick(); tick();
    check("b_if_ready", 32'(if_ready_v[0]), 32'd1);
    check("b_if_rdata", if_rdata_v[0],      32'h0044_FFBB);
    if_req = 1'b0;
    tick();
    wait_all_idle();

    // Starvation: both held; expect D,D,D,D,I,D,D,D,D,I
    d_req = 1'b1; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h80;
    for (int g = 0; g < 10; g++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!m_en_v[0] && (w < 10));
      check($sformatf("starve_grant%0d_seen", g), 32'(m_en_v[0]), 32'd1);
      check($sformatf("starve_grant%0d_addr", g), m_addr_v[0],
            ((g % 5) == 4) ? 32'h80 : 32'h300);
    end
    d_req = 1'b0; if_req = 1'b0;
    tick();
    wait_all_idle();

    // Reset asserted in WAIT abandons the access
    if_req = 1'b1; if_addr = 32'h48;
    tick(); tick();
    check("r_in_wait", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("r_busy",     32'(busy_v[0]),     32'd0);
    check("r_m_en",     32'(m_en_v[0]),     32'd0);
    check("r_m_addr",   m_addr_v[0],        32'd0);
    check("r_if_ready", 32'(if_ready_v[0]), 32'd0);
    check("r_if_rdata", if_rdata_v[0],      32'd0);
    check("r_d_rdata",  d_rdata_v[0],       32'd0);
    if_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_ready_v[0] || d_ready_v[0]) rdy_cnt++;
    end
    check("r_no_ready_after", 32'(rdy_cnt), 32'd0);
    check("r_rdata_ignored",  if_rdata_v[0], 32'd0);
    if_req = 1'b1; if_addr = 32'h4C;
    tick(); tick(); tick(); tick();
    check("r_new_if_ready", 32'(if_ready_v[0]), 32'd1);
    check("r_new_if_rdata", if_rdata_v[0],      32'h004C_FFB3);
    if_req = 1'b0;
    tick();
    wait_all_idle();

    // Latency sweep on all three instances: one fetch, then one load
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 3; k++) begin
        rdy_at[k] = 0;
        rd_at[k]  = '0;
      end
      if (v == 0) begin
        if_req = 1'b1; if_addr = 32'h40;
      end else begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1234;
      end
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (c == 1) begin
          if_req = 1'b0; d_req = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
          if ((v == 0 ? if_ready_v[k] : d_ready_v[k]) && (rdy_at[k] == 0)) begin
            rdy_at[k] = c;
            rd_at[k]  = (v == 0) ? if_rdata_v[k] : d_rdata_v[k];
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("sweep%0d_lat%0d_cycles", v, lat_c[k]), 32'(rdy_at[k]),
              32'(lat_c[k] + 2));
        check($sformatf("sweep%0d_lat%0d_rdata", v, lat_c[k]), rd_at[k],
              (v == 0) ? 32'h8C01_0004 : 32'h1234_EDCB);
      end
      wait_all_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
